// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register busy scoreboard.
// Register 0 is hardwired to zero. Writes commit on the rising edge, and the
// highest-numbered write port wins an address conflict. Reads are combinational
// and can optionally bypass same-cycle write data. Issue marks a destination
// busy. A write carrying wclr releases it, but a same-edge issue of that
// register keeps it busy.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NRD*AW-1:0]     ra,
    output logic [NRD*XLEN-1:0]   rd,
    output logic [NRD-1:0]        rbusy,
    input  logic [NWR-1:0]        we,
    input  logic [NWR*AW-1:0]     wa,
    input  logic [NWR*XLEN-1:0]   wd,
    input  logic [NWR-1:0]        wclr,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_addr,
    output logic [NREGS-1:0]      busy_vec
);

    logic [XLEN-1:0]  mem_r      [NREGS];
    logic [XLEN-1:0]  mem_nxt_s  [NREGS];
    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_nxt_s;

    // Next register contents: later write ports override earlier ones, r0 stays zero
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            mem_nxt_s[r] = mem_r[r];
            if (r != 0) begin
                for (int j = 0; j < NWR; j++) begin
                    if (we[j] && (wa[j*AW +: AW] == AW'(r))) begin
                        mem_nxt_s[r] = wd[j*XLEN +: XLEN];
                    end else begin
                        mem_nxt_s[r] = mem_nxt_s[r];
                    end
                end
            end else begin
                mem_nxt_s[r] = {XLEN{1'b0}};
            end
        end
    end

    // Next busy bitmap: clears from completing writes first, then the issue set overrides
    always_comb begin
        busy_nxt_s = busy_r;
        for (int j = 0; j < NWR; j++) begin
            if (we[j] && wclr[j]) begin
                busy_nxt_s[wa[j*AW +: AW]] = 1'b0;
            end else begin
                busy_nxt_s = busy_nxt_s;
            end
        end
        if (iss_valid) begin
            busy_nxt_s[iss_addr] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Register array and busy bitmap state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++) begin
                mem_r[r] <= {XLEN{1'b0}};
            end
            busy_r <= {NREGS{1'b0}};
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                mem_r[r] <= mem_nxt_s[r];
            end
            busy_r <= busy_nxt_s;
        end
    end

    // Read ports: stored value, optional same-cycle write bypass, busy qualified by completing writes
    always_comb begin
        rd    = {(NRD*XLEN){1'b0}};
        rbusy = {NRD{1'b0}};
        for (int i = 0; i < NRD; i++) begin
            logic [AW-1:0]   addr_s;
            logic [XLEN-1:0] data_s;
            logic            clr_hit_s;
            addr_s    = ra[i*AW +: AW];
            data_s    = mem_r[addr_s];
            clr_hit_s = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                if ((BYPASS != 0) && we[j] && (wa[j*AW +: AW] == addr_s)) begin
                    data_s    = wd[j*XLEN +: XLEN];
                    clr_hit_s = clr_hit_s | wclr[j];
                end else begin
                    data_s    = data_s;
                    clr_hit_s = clr_hit_s;
                end
            end
            if (!reset_n || (addr_s == {AW{1'b0}})) begin
                rd[i*XLEN +: XLEN] = {XLEN{1'b0}};
                rbusy[i]           = 1'b0;
            end else begin
                rd[i*XLEN +: XLEN] = data_s;
                rbusy[i]           = busy_r[addr_s] & ~clr_hit_s;
            end
        end
    end

    // Debug/stall view of the busy bitmap, forced clear while reset is held
    always_comb begin
        if (!reset_n) begin
            busy_vec = {NREGS{1'b0}};
        end else begin
            busy_vec = busy_r;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp. It runs one bypassing instance
// and one non-bypassing instance side by side on shared inputs.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int AW = 5;

    logic                clk;
    logic                reset_n;
    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rd_b, rd_n;
    logic [NRD-1:0]      rbusy_b, rbusy_n;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   wa;
    logic [NWR*XLEN-1:0] wd;
    logic [NWR-1:0]      wclr;
    logic                iss_valid;
    logic [AW-1:0]       iss_addr;
    logic [NREGS-1:0]    busy_vec_b, busy_vec_n;

    int checks = 0;
    int errors = 0;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .ra(ra), .rd(rd_b), .rbusy(rbusy_b),
        .we(we), .wa(wa), .wd(wd), .wclr(wclr),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .busy_vec(busy_vec_b)
    );

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_n (
        .clk(clk), .reset_n(reset_n), .ra(ra), .rd(rd_n), .rbusy(rbusy_n),
        .we(we), .wa(wa), .wd(wd), .wclr(wclr),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .busy_vec(busy_vec_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        we = '0; wa = '0; wd = '0; wclr = '0;
        iss_valid = 1'b0; iss_addr = '0;
    endtask

    task automatic wr(input int j, input logic [AW-1:0] a, input logic [XLEN-1:0] d, input logic c);
        we[j] = 1'b1;
        wa[j*AW +: AW] = a;
        wd[j*XLEN +: XLEN] = d;
        wclr[j] = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset_n = 1'b0;
        ra = '0;
        idle();
        tick();
        // reset held: outputs zero even with a bypassing write present
        wr(0, 5'd5, 32'hAAAA_5555, 1'b1);
        ra = {5'd5, 5'd5};
        #1;
        chk("rst_rd0", rd_b[31:0], 32'h0);
        chk("rst_rd1", rd_b[63:32], 32'h0);
        chk("rst_busy", busy_vec_b, 32'h0);
        chk("rst_rbusy", {30'h0, rbusy_b}, 32'h0);
        tick();
        idle();
        reset_n = 1'b1;

        // write r5 then read on both ports
        wr(0, 5'd5, 32'hDEAD_BEEF, 1'b0);
        tick();
        idle();
        ra = {5'd5, 5'd5};
        #1;
        chk("r5_rd0", rd_b[31:0], 32'hDEAD_BEEF);
        chk("r5_rd1", rd_b[63:32], 32'hDEAD_BEEF);
        chk("r5_nb_rd0", rd_n[31:0], 32'hDEAD_BEEF);
        reset_n = 1'b0;
        #1;
        chk("midrst_rd0", rd_b[31:0], 32'h0);
        chk("midrst_nb_rd1", rd_n[63:32], 32'h0);
        tick();
        reset_n = 1'b1;

        // write-port conflict on r7
        wr(0, 5'd7, 32'h11, 1'b0);
        wr(1, 5'd7, 32'h22, 1'b0);
        ra = {5'd0, 5'd7};
        #1;
        chk("r7_byp", rd_b[31:0], 32'h22);
        chk("r7_nobyp_old", rd_n[31:0], 32'h0);
        tick();
        idle();
        #1;
        chk("r7_stored", rd_b[31:0], 32'h22);
        chk("r7_nobyp_new", rd_n[31:0], 32'h22);

        // r0 write and r0 issue are ignored
        wr(0, 5'd0, 32'hFFFF_FFFF, 1'b1);
        iss_valid = 1'b1; iss_addr = 5'd0;
        ra = {5'd0, 5'd0};
        #1;
        chk("r0_byp", rd_b[31:0], 32'h0);
        tick();
        idle();
        #1;
        chk("r0_rd", rd_b[31:0], 32'h0);
        chk("r0_busy", busy_vec_b, 32'h0);

        // issue r3, two idle cycles, then completing write
        iss_valid = 1'b1; iss_addr = 5'd3;
        ra = {5'd0, 5'd3};
        #1;
        chk("r3_iss_same_cycle", {31'h0, rbusy_b[0]}, 32'h0);
        tick();
        idle();
        #1;
        chk("r3_idle1_rbusy", {31'h0, rbusy_b[0]}, 32'h1);
        chk("r3_busy_vec", busy_vec_b, 32'h0000_0008);
        tick();
        #1;
        chk("r3_idle2_rbusy", {31'h0, rbusy_b[0]}, 32'h1);
        tick();
        wr(0, 5'd3, 32'h55, 1'b1);
        #1;
        chk("r3_wr_rbusy", {31'h0, rbusy_b[0]}, 32'h0);
        chk("r3_wr_rd", rd_b[31:0], 32'h55);
        chk("r3_nobyp_rbusy", {31'h0, rbusy_n[0]}, 32'h1);
        chk("r3_nobyp_rd", rd_n[31:0], 32'h0);
        tick();
        idle();
        #1;
        chk("r3_cleared", busy_vec_b, 32'h0);
        chk("r3_nobyp_cleared", busy_vec_n, 32'h0);

        // same-edge issue and clearing write of r9: set wins
        iss_valid = 1'b1; iss_addr = 5'd9;
        wr(1, 5'd9, 32'h99, 1'b1);
        tick();
        idle();
        ra = {5'd9, 5'd0};
        #1;
        chk("r9_data", rd_b[63:32], 32'h99);
        chk("r9_busy_vec", busy_vec_b, 32'h0000_0200);
        chk("r9_rbusy1", {31'h0, rbusy_b[1]}, 32'h1);

        // wclr=0 write to busy r4 keeps it busy; a later wclr=1 clears it
        iss_valid = 1'b1; iss_addr = 5'd4;
        tick();
        idle();
        wr(0, 5'd4, 32'h44, 1'b0);
        ra = {5'd0, 5'd4};
        #1;
        chk("r4_noclr_rbusy", {31'h0, rbusy_b[0]}, 32'h1);
        tick();
        idle();
        #1;
        chk("r4_data", rd_b[31:0], 32'h44);
        chk("r4_still_busy", busy_vec_b, 32'h0000_0210);
        wr(1, 5'd4, 32'h45, 1'b1);
        tick();
        idle();
        #1;
        chk("r4_cleared", busy_vec_b, 32'h0000_0200);
        chk("r4_data2", rd_b[31:0], 32'h45);

        // two ports, different addresses, same cycle
        wr(0, 5'd10, 32'h0000_000A, 1'b0);
        wr(1, 5'd11, 32'h0000_000B, 1'b0);
        tick();
        idle();
        ra = {5'd11, 5'd10};
        #1;
        chk("dual_r10", rd_n[31:0], 32'h0000_000A);
        chk("dual_r11", rd_n[63:32], 32'h0000_000B);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file with scoreboard, successor to the single-write, two-read core register file.
- Adds configurable width, depth, read-port count and write-port count.
- Adds hardwired-zero register 0, same-cycle write-to-read bypass, and per-register busy (pending-write) tracking.
- Sits between decode/issue and writeback of the pipelined core.
- Issue marks destinations busy. Writeback clears them. Decode reads operands together with a per-operand busy flag to drive hazard stalls.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of registers (power of two, >=2). AW = $clog2(NREGS).
- NRD, 2, number of read ports.
- NWR, 2, number of write ports.
- BYPASS, 1, 1 = a read returns same-cycle write data; 0 = a read returns stored value.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- ra  input  NRD*AW  read addresses; port i = ra[i*AW +: AW].
- rd  output  NRD*XLEN  read data; port i = rd[i*XLEN +: XLEN].
- rbusy  output  NRD  1 = operand i has a pending write that is not resolved this cycle.
- we  input  NWR  write enables.
- wa  input  NWR*AW  write addresses.
- wd  input  NWR*XLEN  write data.
- wclr  input  NWR  1 = this write also clears the busy bit of wa[j].
- iss_valid  input  1  issue strobe: mark iss_addr busy.
- iss_addr  input  AW  destination register of the issued instruction.
- busy_vec  output  NREGS  current busy bits, for debug and the stall unit.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All registers become 0 and all busy bits become 0.
  - rd reads 0 and rbusy/busy_vec read 0 while reset is held.
  - Reset releases synchronously to the next rising clk edge. No write or issue in that cycle is lost except during the low phase.
- Register 0:
  - Always reads 0. Writes to it are discarded.
  - Never marked busy: iss_addr == 0 is ignored, and busy_vec[0] is always 0.
- Writes:
  - On each rising edge, every port j with we[j] = 1 stores wd[j] into wa[j].
  - Same-address conflict between write ports: the highest-index port wins (deterministic priority).
  - Writes to different addresses all commit in the same cycle.
- Reads: combinational, zero latency.
  - BYPASS = 1 and some enabled write port targets ra[i] (non-zero): rd[i] = that port's wd, using the same highest-index priority.
  - Otherwise rd[i] = stored value.
- Busy tracking: one bit per register.
  - Set on a rising edge when iss_valid = 1 and iss_addr != 0.
  - Cleared on a rising edge when we[j] = 1, wclr[j] = 1 and wa[j] matches.
  - Simultaneous set and clear of the same register: set wins, because the new issue supersedes the completing writer.
  - Clear of a register that is not busy: no effect, no error.
  - A write with wclr = 0 updates data only; the busy bit is unchanged.
- rbusy[i] (combinational):
  - rbusy[i] = busy[ra[i]] AND NOT (BYPASS AND some write port with we = 1 and wclr = 1 targets ra[i] this cycle).
  - ra[i] == 0 gives rbusy[i] = 0.
  - iss_valid in the current cycle does not affect rbusy until the next edge.
- All read ports are independent. Any number of ports may read the same address.
- No internal FSM beyond the busy bitmap. Throughput is one issue and NWR writes per cycle, with no back-pressure.

Test Plan:
- Reset, then write 0xDEADBEEF to r5 via port 0 and read r5 next cycle on both read ports.
  -> rd = 0xDEADBEEF on both ports.
  -> Assert reset_n low mid-cycle: rd drops to 0 immediately, without waiting for clk.
- Port 0 writes r7 = 0x11 and port 1 writes r7 = 0x22 in the same cycle.
  -> Stored r7 = 0x22.
  -> With BYPASS = 1, a same-cycle read of r7 returns 0x22.
  -> With BYPASS = 0, the same-cycle read returns the old value and the next cycle returns 0x22.
- Write 0xFFFFFFFF to r0, and issue iss_addr = 0.
  -> r0 reads 0, busy_vec[0] = 0.
- Issue r3, then two idle cycles, then a write to r3 = 0x55 with wclr = 1.
  -> rbusy = 1 for a read of r3 during the idle cycles.
  -> In the write cycle rbusy = 0 and rd = 0x55 (BYPASS = 1).
  -> busy_vec[3] = 0 afterwards.
- Same edge: iss_valid with iss_addr = 9, and a write to r9 with wclr = 1.
  -> Data is stored and busy_vec[9] = 1 after the edge.
- Write with wclr = 0 to a busy r4.
  -> Data is updated and busy_vec[4] stays 1.
  -> A later write with wclr = 1 to r4 clears it.
